// File: rtl/norm_shift_controller.sv
// ---------------------------------------------------------------------------
// norm_shift_controller
//
// Purpose:
//   Normalisation sequencer for the half-precision adder's post-add mantissa.
//   It steers an external 0-3 bit left shifter, one pass per clock. Each pass
//   moves the mantissa left and lowers the exponent by the same amount. It
//   stops when the mantissa MSB is set or when the exponent reaches 1. If the
//   exponent reaches 1 before the MSB is set, the result is subnormal.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake (in_ready high only in IDLE)
//   in_mant, in_exp     - unnormalised mantissa and biased exponent
//   shift_in            - mantissa presented to the external shifter
//   shift_ctrl          - shift amount to the shifter (non-zero only in SHIFT)
//   shift_out           - combinational shifter result
//   out_valid/out_ready - downstream handshake (out_valid high only in DONE)
//   out_mant, out_exp   - normalised mantissa and adjusted exponent
//   out_shift_total     - total left shift applied (0-10)
//   out_zero            - input mantissa was zero
//   out_denorm          - exponent floor reached with out_mant MSB clear
// ---------------------------------------------------------------------------
module norm_shift_controller #(
    parameter int MANT_W = 11,
    parameter int EXP_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic [MANT_W-1:0] shift_in,
    output logic [1:0]        shift_ctrl,
    input  logic [MANT_W-1:0] shift_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [3:0]        out_shift_total,
    output logic              out_zero,
    output logic              out_denorm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [MANT_W-1:0] mant_reg;
    logic [EXP_W-1:0]  exp_reg;
    logic [3:0]        total_reg;
    logic              zero_reg;
    logic              denorm_reg;

    logic [3:0]        lz;
    logic              lz_hit;
    logic [EXP_W-1:0]  room;
    logic [1:0]        amt;

    // Count the leading zeros of the working mantissa. Scan from the MSB down
    // and stop counting at the first set bit.
    always_comb begin
        lz     = '0;
        lz_hit = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!lz_hit) begin
                if (mant_reg[i]) begin
                    lz_hit = 1'b1;
                end else begin
                    lz = lz + 4'd1;
                end
            end
        end
    end

    // Shift for this pass: the smallest of the shifter reach (3), the leading
    // zeros, and the distance to the exponent floor of 1. In SHIFT, exp_reg is
    // always at least 1, so room cannot wrap.
    always_comb begin
        room = exp_reg - EXP_W'(1);
        amt  = 2'd3;
        if (lz < 4'd3) begin
            amt = lz[1:0];
        end
        if (room < EXP_W'(amt)) begin
            amt = room[1:0];
        end
    end

    assign shift_in   = mant_reg;
    assign shift_ctrl = (state == SHIFT) ? amt : 2'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mant_reg   <= '0;
            exp_reg    <= '0;
            total_reg  <= '0;
            zero_reg   <= 1'b0;
            denorm_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_reg   <= in_mant;
                        total_reg  <= '0;
                        denorm_reg <= 1'b0;
                        if (in_mant == '0) begin
                            // A zero mantissa is reported with exponent 0.
                            exp_reg  <= '0;
                            zero_reg <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // Exponent 0 (a subnormal input) is scaled like exponent 1.
                            exp_reg  <= (in_exp == '0) ? EXP_W'(1) : in_exp;
                            zero_reg <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (amt != 2'd0) begin
                        mant_reg  <= shift_out;
                        exp_reg   <= exp_reg - EXP_W'(amt);
                        total_reg <= total_reg + 4'(amt);
                    end else begin
                        denorm_reg <= ~mant_reg[MANT_W-1];
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready        = (state == IDLE);
    assign out_valid       = (state == DONE);
    assign out_mant        = mant_reg;
    assign out_exp         = exp_reg;
    assign out_shift_total = total_reg;
    assign out_zero        = zero_reg;
    assign out_denorm      = denorm_reg;

endmodule

// File: tb/tb_norm_shift_controller.sv
// ---------------------------------------------------------------------------
// tb_norm_shift_controller
//
// Self-checking bench for norm_shift_controller. It models the external
// 11-bit 0-3 bit left shifter and applies a table of directed vectors with
// hand-computed results. Hand-written sequences cover output stall and
// mid-operation reset.
// ---------------------------------------------------------------------------
module tb_norm_shift_controller;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_mant;
    logic [4:0]  in_exp;
    logic [10:0] shift_in;
    logic [1:0]  shift_ctrl;
    logic [10:0] shift_out;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_mant;
    logic [4:0]  out_exp;
    logic [3:0]  out_shift_total;
    logic        out_zero;
    logic        out_denorm;

    int checks = 0;
    int errors = 0;

    // Shift amounts seen during the last transaction, one entry per cycle.
    int sc_seq[0:19];
    int sc_n;

    typedef struct {
        logic [10:0] mant;
        logic [4:0]  exp;
        logic [10:0] e_mant;
        logic [4:0]  e_exp;
        int          e_total;
        int          e_zero;
        int          e_denorm;
        int          e_lat;
    } vec_t;

    vec_t tbl[8];

    norm_shift_controller #(.MANT_W(11), .EXP_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_mant         (in_mant),
        .in_exp          (in_exp),
        .shift_in        (shift_in),
        .shift_ctrl      (shift_ctrl),
        .shift_out       (shift_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_mant        (out_mant),
        .out_exp         (out_exp),
        .out_shift_total (out_shift_total),
        .out_zero        (out_zero),
        .out_denorm      (out_denorm)
    );

    // External shifter model.
    assign shift_out = shift_in << shift_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Apply one transaction. The accept happens at the first rising edge.
    // Sampling is done 1 time unit after each rising edge. If rel is set,
    // the result is released afterwards and the return to IDLE is checked.
    task automatic run_txn(input vec_t v, input bit rel, input string tag);
        int n;
        int sum;
        chk({tag, " in_ready before accept"}, int'(in_ready), 1);
        @(negedge clk);
        in_mant  = v.mant;
        in_exp   = v.exp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mant  = 11'h7ff;  // garbage: inputs must be sampled only on accept
        in_exp   = 5'd31;
        n    = 1;
        sum  = 0;
        sc_n = 0;
        while (!out_valid && n < 20) begin
            sc_seq[sc_n] = int'(shift_ctrl);
            sc_n++;
            sum += int'(shift_ctrl);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"},      n,                     v.e_lat);
        chk({tag, " out_mant"},     int'(out_mant),        int'(v.e_mant));
        chk({tag, " out_exp"},      int'(out_exp),         int'(v.e_exp));
        chk({tag, " total"},        int'(out_shift_total), v.e_total);
        chk({tag, " zero"},         int'(out_zero),        v.e_zero);
        chk({tag, " denorm"},       int'(out_denorm),      v.e_denorm);
        chk({tag, " shift sum"},    sum,                   v.e_total);
        chk({tag, " ctrl in DONE"}, int'(shift_ctrl),      0);
        $display("txn %s: mant=0x%03h exp=%0d -> mant=0x%03h exp=%0d total=%0d zero=%0d denorm=%0d lat=%0d",
                 tag, v.mant, v.exp, out_mant, out_exp, out_shift_total, out_zero, out_denorm, n);
        if (rel) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, " in_ready after release"},  int'(in_ready),  1);
            chk({tag, " out_valid after release"}, int'(out_valid), 0);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        bit seen;

        //         mant    exp    e_mant  e_exp  tot z  d  lat
        tbl[0] = '{11'h400, 5'd15, 11'h400, 5'd15, 0,  0, 0, 2};
        tbl[1] = '{11'h001, 5'd20, 11'h400, 5'd10, 10, 0, 0, 6};
        tbl[2] = '{11'h080, 5'd2,  11'h100, 5'd1,  1,  0, 1, 3};
        tbl[3] = '{11'h000, 5'd9,  11'h000, 5'd0,  0,  1, 0, 1};
        tbl[4] = '{11'h030, 5'd0,  11'h030, 5'd1,  0,  0, 1, 2};
        tbl[5] = '{11'h001, 5'd4,  11'h008, 5'd1,  3,  0, 1, 3};
        tbl[6] = '{11'h1ff, 5'd30, 11'h7fc, 5'd28, 2,  0, 0, 3};
        tbl[7] = '{11'h3ff, 5'd1,  11'h3ff, 5'd1,  0,  0, 1, 2};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        out_ready = 1'b0;

        // Check the state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",   int'(in_ready),        1);
        chk("reset out_valid",  int'(out_valid),       0);
        chk("reset shift_ctrl", int'(shift_ctrl),      0);
        chk("reset out_mant",   int'(out_mant),        0);
        chk("reset out_exp",    int'(out_exp),         0);
        chk("reset total",      int'(out_shift_total), 0);
        chk("reset zero",       int'(out_zero),        0);
        chk("reset denorm",     int'(out_denorm),      0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Output stall. First check the per-pass shift sequence.
        run_txn(tbl[1], 1'b0, "stall");
        chk("stall seq len", sc_n, 5);
        chk("stall seq0", sc_seq[0], 3);
        chk("stall seq1", sc_seq[1], 3);
        chk("stall seq2", sc_seq[2], 3);
        chk("stall seq3", sc_seq[3], 1);
        chk("stall seq4", sc_seq[4], 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mant  = 11'h123;
            in_exp   = 5'd7;
            @(posedge clk);
            #1;
            chk("stall out_valid", int'(out_valid),       1);
            chk("stall in_ready",  int'(in_ready),        0);
            chk("stall out_mant",  int'(out_mant),        11'h400);
            chk("stall out_exp",   int'(out_exp),         10);
            chk("stall total",     int'(out_shift_total), 10);
            $display("stall cycle %0d: out_valid=%0d in_ready=%0d mant=0x%03h exp=%0d",
                     c, out_valid, in_ready, out_mant, out_exp);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release in_ready",  int'(in_ready),  1);
        chk("release out_valid", int'(out_valid), 0);
        @(negedge clk);
        out_ready = 1'b0;
        run_txn(tbl[0], 1'b1, "after_stall");

        // Reset during the second shift pass.
        @(negedge clk);
        in_mant  = 11'h001;
        in_exp   = 5'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("second pass shift_ctrl", int'(shift_ctrl), 3);
        reset = 1'b1;
        #1;
        chk("abort in_ready",   int'(in_ready),   1);
        chk("abort out_valid",  int'(out_valid),  0);
        chk("abort shift_ctrl", int'(shift_ctrl), 0);
        chk("abort out_mant",   int'(out_mant),   0);
        chk("abort out_exp",    int'(out_exp),    0);
        $display("abort: reset asserted mid-SHIFT, in_ready=%0d out_valid=%0d", in_ready, out_valid);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort no out_valid", int'(seen), 0);
        run_txn(tbl[2], 1'b1, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/norm_shift_controller.md
Name: norm_shift_controller

Overview:
Multi-cycle normalisation sequencer for the half-precision adder's post-add mantissa. It drives the external 11-bit, 0-3-bit left shifter through repeated passes, one pass per clock, until the mantissa MSB is set or the exponent floor is reached. On every pass it decrements the exponent by the applied shift. It sits between the significand adder/subtractor stage and the rounding/pack stage, with valid/ready handshakes on both sides.

Parameters:
MANT_W, 11, mantissa width including the hidden bit; fixed to the shifter width.
EXP_W, 5, biased exponent width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream mantissa/exponent valid
in_ready  output  1  controller can accept; high only in IDLE
in_mant  input  MANT_W  unnormalised mantissa
in_exp  input  EXP_W  biased exponent
shift_in  output  MANT_W  data driven to shifter input (= mant_reg)
shift_ctrl  output  2  shift amount to shifter (0-3)
shift_out  input  MANT_W  shifter result (combinational from shift_in/shift_ctrl)
out_valid  output  1  normalised result valid; high only in DONE
out_ready  input  1  downstream accepts
out_mant  output  MANT_W  normalised mantissa
out_exp  output  EXP_W  adjusted exponent
out_shift_total  output  4  total left shift applied (0-10)
out_zero  output  1  input mantissa was zero
out_denorm  output  1  result is subnormal: exponent floor reached with out_mant[10]=0

Behaviour:
- FSM with states IDLE, SHIFT and DONE. Reset forces IDLE; mant_reg, exp_reg, total, zero and denorm clear to 0.
- Reset values: in_ready=1, out_valid=0, shift_ctrl=0, all data outputs 0.
- Reset asserted mid-operation aborts immediately. No partial result is emitted, and the first accept is possible in the cycle after deassertion.
- IDLE:
  - On in_valid&in_ready, latch in_mant; latch the exponent as max(in_exp,1) (input exponent 0 is treated as 1); clear total.
  - If in_mant==0: go to DONE with zero=1 and out_exp=0.
  - Otherwise go to SHIFT.
- SHIFT:
  - lz = leading zeros of mant_reg (0-10).
  - amt = min(3, lz, exp_reg-1). This is combinational and drives shift_ctrl; shift_in=mant_reg.
  - amt>0: mant_reg<=shift_out; exp_reg<=exp_reg-amt; total<=total+amt; stay in SHIFT.
  - amt==0: go to DONE; denorm<=~mant_reg[10].
- shift_ctrl is 0 in IDLE and DONE. The shifter output is used only in SHIFT.
- DONE:
  - out_valid=1; outputs hold stable while out_ready=0.
  - On out_ready: return to IDLE. in_ready rises the next cycle; there is no same-cycle accept.
- Latency (accept in cycle T):
  - Zero input: out_valid in T+1.
  - Otherwise: out_valid in T+2+P, where P = ceil(min(lz, exp-1)/3) and P ≤ 4.
- Exponent never goes below 1 for a nonzero mantissa. The subtraction cannot wrap because amt ≤ exp_reg-1.
- in_valid is ignored outside IDLE. in_mant and in_exp are sampled only on accept.

Test Plan:
- in_mant=0x400, in_exp=15, accept T -> out_valid T+2, out_mant=0x400, out_exp=15, total=0, zero=0, denorm=0; shift_ctrl stays 0.
- in_mant=0x001, in_exp=20 -> shift_ctrl sequence 3,3,3,1 then 0; out_mant=0x400, out_exp=10, total=10, out_valid at T+6.
- in_mant=0x080, in_exp=2 -> one pass with shift_ctrl=1; out_mant=0x100, out_exp=1, total=1, denorm=1.
- in_mant=0x000, in_exp=9 -> out_valid T+1, zero=1, out_exp=0, out_mant=0, total=0, no shift passes.
- in_mant=0x030, in_exp=0 -> exponent treated as 1, no shift; out_exp=1, denorm=1, out_mant=0x030.
- in_mant=0x001, in_exp=20 with out_ready held 0 for 5 cycles:
  - While out_ready is low -> outputs stable, in_ready=0, and a new in_valid is ignored.
  - After release -> IDLE, then accept next.
- Reset pulsed during the second SHIFT pass -> out_valid never asserts, in_ready=1 after reset, and a new transaction completes normally.
